bc_msg_arbiter: RTL and testbench
=================================

Name: bc_msg_arbiter

Overview:
- Shares the single broadcast-message fabric between all RISC-V core wrappers on the board.
- Each core's registered bc_msg_out channel is a requester. The arbiter grants one message per cycle, round-robin, and registers it onto a broadcast bus.
- The broadcast bus fans out to every core's bc_msg_in port. That port has no backpressure.
- Also flushes messages from cores held in core_reset and keeps per-core statistics for the host status path.

Parameters:
- CORE_COUNT, 8, number of requesting cores.
- CORE_ID_WIDTH, 3, clog2(CORE_COUNT); width of core index.
- MSG_WIDTH, 47, broadcast message width (32 data + 4 strobe + 11 word address).
- CNT_WIDTH, 16, width of statistics counters.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- core_reset  input  CORE_COUNT  per-core reset flags; bit i set means core i is in reset.
- arb_enable  input  1  when low, no new grants are issued (flushing still occurs).
- s_msg  input  CORE_COUNT*MSG_WIDTH  per-core messages; core i occupies bits [i*MSG_WIDTH +: MSG_WIDTH].
- s_valid  input  CORE_COUNT  per-core message valid.
- s_ready  output  CORE_COUNT  per-core accept.
- bcast_msg  output  MSG_WIDTH  registered broadcast message.
- bcast_valid  output  1  broadcast valid, one-cycle pulse per message.
- bcast_src  output  CORE_ID_WIDTH  index of the originating core.
- stat_sel  input  CORE_ID_WIDTH  core selected for statistics readout or clear.
- stat_clear  input  1  pulse; clears the sent counter of the core selected by stat_sel.
- stat_sent  output  CNT_WIDTH  sent-message count of the core selected by stat_sel.
- stat_dropped  output  CNT_WIDTH  total messages flushed from cores in reset.

Behaviour:
- Reset (rst=1 at a clk edge):
  - bcast_valid=0, bcast_msg=0, bcast_src=0.
  - All sent counters and the dropped counter are 0.
  - Round-robin pointer is 0, so core 0 has top priority.
  - s_ready is 0 throughout the reset cycle.
  - Reset mid-operation discards any pending output; no partial broadcast follows.
- Eligibility: req[i] = s_valid[i] & ~core_reset[i] & arb_enable.
- Grant (combinational, one-hot or zero):
  - Choose the first req[i] scanning from index ptr upward, wrapping modulo CORE_COUNT.
  - s_ready[i] = grant[i] | core_reset[i]. Cores in reset always see ready, so their stale messages drain.
  - s_ready is not dependent on any output ready; at most one message is accepted per cycle.
- Pointer update: on any grant to core g, ptr <= (g+1) mod CORE_COUNT. With no grant, ptr holds.
- Output stage, updated every cycle:
  - bcast_valid <= |grant; bcast_msg <= s_msg of the granted core; bcast_src <= g.
  - With no grant, bcast_valid <= 0 and bcast_msg/bcast_src hold their previous values.
  - Latency is exactly 1 cycle from the accept edge to bcast_valid.
- Throughput:
  - 1 message per cycle aggregate.
  - With all CORE_COUNT cores continuously valid, each is granted exactly once every CORE_COUNT cycles, in order ptr, ptr+1, ...
- Flush: s_valid[i] & core_reset[i] counts as a drop.
  - dropped counter += popcount of dropped requests that cycle, saturating at all-ones.
  - Dropped messages are never broadcast.
- Sent counters: on grant to g, sent[g] += 1, saturating at 2^CNT_WIDTH-1.
- stat_clear semantics:
  - stat_clear clears sent[stat_sel].
  - If a grant to the same core coincides, clear wins and the counter becomes 0.
  - stat_clear does not affect the dropped counter; only rst clears it.
- Statistics readout: stat_sent is registered, so it reflects sent[stat_sel] from the previous cycle's state, with 1-cycle read latency.
- arb_enable low:
  - No grants; ptr holds; bcast_valid goes 0 on the next cycle.
  - Non-reset cores see s_ready=0 and must hold their message.
- core_reset asserting in the same cycle a core would win: that core is ineligible, its message is dropped, and the next eligible core wins that cycle.

Test Plan:
- rst, then core 3 only, s_valid=1, msg=0x0AB_CDEF01 -> s_ready[3]=1 that cycle; next cycle bcast_valid=1, bcast_msg=0x0AB_CDEF01, bcast_src=3; stat_sel=3 reads stat_sent=1 two cycles after the accept.
- All 8 cores continuously valid for 16 cycles after rst -> grants 0,1,...,7,0,...,7; each sent counter=2; bcast_valid high for 16 consecutive cycles.
- Cores 2 and 5 valid, core_reset[5]=1 -> only core 2 broadcast; s_ready[5]=1; stat_dropped=1; nothing from core 5 ever appears on bcast_src.
- arb_enable=0 for 4 cycles with cores 1 and 6 valid -> s_ready=0, bcast_valid=0. Re-enable with ptr at 0 -> core 1 granted, then core 6 next cycle.
- Preload sent[0] to 0xFFFF via 65535 grants, then grant again -> stays 0xFFFF. stat_clear with stat_sel=0 plus a simultaneous grant to core 0 -> 0.
- rst asserted in the cycle after a grant to core 4 -> bcast_valid=0 in the following cycle; counters 0; next grant follows ptr=0 priority.

Source files
------------

// File: rtl/bc_msg_arbiter.sv
// bc_msg_arbiter: round-robin arbiter that shares one broadcast-message bus
// between all core wrappers. One message is granted per cycle and registered
// onto the bus. Messages from cores held in reset are drained and counted as
// drops, and per-core sent counters feed the host status path.
module bc_msg_arbiter #(
    parameter int CORE_COUNT    = 8,
    parameter int CORE_ID_WIDTH = 3,
    parameter int MSG_WIDTH     = 47,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [CORE_COUNT-1:0]             core_reset,
    input  logic                              arb_enable,
    input  logic [CORE_COUNT*MSG_WIDTH-1:0]   s_msg,
    input  logic [CORE_COUNT-1:0]             s_valid,
    output logic [CORE_COUNT-1:0]             s_ready,
    output logic [MSG_WIDTH-1:0]              bcast_msg,
    output logic                              bcast_valid,
    output logic [CORE_ID_WIDTH-1:0]          bcast_src,
    input  logic [CORE_ID_WIDTH-1:0]          stat_sel,
    input  logic                              stat_clear,
    output logic [CNT_WIDTH-1:0]              stat_sent,
    output logic [CNT_WIDTH-1:0]              stat_dropped
);

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Counter add of a small per-cycle amount, sticking at all-ones.
    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [CORE_ID_WIDTH:0] b);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + (CNT_WIDTH+1)'(b);
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    // Number of set bits in a per-core vector.
    function automatic logic [CORE_ID_WIDTH:0] popcount(input logic [CORE_COUNT-1:0] v);
        logic [CORE_ID_WIDTH:0] c;
        c = '0;
        for (int i = 0; i < CORE_COUNT; i++) begin
            c = c + (CORE_ID_WIDTH+1)'(v[i]);
        end
        return c;
    endfunction

    logic [CORE_ID_WIDTH-1:0] ptr;
    logic [CORE_COUNT-1:0]    req;
    logic [CORE_COUNT-1:0]    grant;
    logic [CORE_ID_WIDTH-1:0] gidx;
    logic                     any_grant;
    logic [CORE_COUNT-1:0]    drop_vec;
    logic [CNT_WIDTH-1:0]     sent [CORE_COUNT];
    logic [MSG_WIDTH-1:0]     grant_msg;
    logic [CORE_ID_WIDTH-1:0] ptr_next;

    // Nothing is granted during the reset cycle so no state is disturbed and
    // cores never see an accept that the reset would then discard.
    assign req      = s_valid & ~core_reset & {CORE_COUNT{arb_enable & ~rst}};
    assign drop_vec = s_valid & core_reset;
    assign s_ready  = rst ? '0 : (grant | core_reset);

    // Round-robin scan: first requester at or after ptr, wrapping around.
    always_comb begin
        int idx;
        grant     = '0;
        gidx      = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int k = 0; k < CORE_COUNT; k++) begin
            idx = int'(ptr) + k;
            if (idx >= CORE_COUNT) begin
                idx = idx - CORE_COUNT;
            end
            if (!any_grant && req[idx]) begin
                any_grant  = 1'b1;
                grant[idx] = 1'b1;
                gidx       = CORE_ID_WIDTH'(idx);
            end
        end
    end

    assign grant_msg = s_msg[int'(gidx)*MSG_WIDTH +: MSG_WIDTH];
    assign ptr_next  = (gidx == CORE_ID_WIDTH'(CORE_COUNT-1)) ? '0 : gidx + 1'b1;

    // Priority pointer moves just past the winner; it holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (any_grant) begin
            ptr <= ptr_next;
        end
    end

    // Broadcast register: valid pulses per grant, payload holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcast_valid <= 1'b0;
            bcast_msg   <= '0;
            bcast_src   <= '0;
        end else begin
            bcast_valid <= any_grant;
            if (any_grant) begin
                bcast_msg <= grant_msg;
                bcast_src <= gidx;
            end
        end
    end

    // Per-core sent counters; a clear beats a coincident grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CORE_COUNT; i++) begin
                sent[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CORE_COUNT; i++) begin
                if (stat_clear && (stat_sel == CORE_ID_WIDTH'(i))) begin
                    sent[i] <= '0;
                end else if (grant[i]) begin
                    sent[i] <= sat_inc(sent[i]);
                end
            end
        end
    end

    // Global drop counter for messages flushed from cores in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_dropped <= '0;
        end else begin
            stat_dropped <= sat_add(stat_dropped, popcount(drop_vec));
        end
    end

    // Registered readout of the selected core's sent counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_sent <= '0;
        end else if (int'(stat_sel) < CORE_COUNT) begin
            stat_sent <= sent[stat_sel];
        end else begin
            stat_sent <= '0;
        end
    end

endmodule

// File: tb/tb_bc_msg_arbiter.sv
// Testbench for bc_msg_arbiter: randomized and directed stimulus, a
// behavioural reference model, and a scoreboard drained by a monitor.
module tb_bc_msg_arbiter;

    localparam int N  = 8;
    localparam int IW = 3;
    localparam int MW = 47;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      core_reset = '0;
    logic              arb_enable = 1'b0;
    logic [N*MW-1:0]   s_msg;
    logic [N-1:0]      s_valid = '0;
    logic [N-1:0]      s_ready;
    logic [MW-1:0]     bcast_msg;
    logic              bcast_valid;
    logic [IW-1:0]     bcast_src;
    logic [IW-1:0]     stat_sel = '0;
    logic              stat_clear = 1'b0;
    logic [CW-1:0]     stat_sent;
    logic [CW-1:0]     stat_dropped;

    logic [MW-1:0]     m [N];

    bc_msg_arbiter #(.CORE_COUNT(N), .CORE_ID_WIDTH(IW), .MSG_WIDTH(MW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .core_reset(core_reset), .arb_enable(arb_enable),
        .s_msg(s_msg), .s_valid(s_valid), .s_ready(s_ready),
        .bcast_msg(bcast_msg), .bcast_valid(bcast_valid), .bcast_src(bcast_src),
        .stat_sel(stat_sel), .stat_clear(stat_clear),
        .stat_sent(stat_sent), .stat_dropped(stat_dropped)
    );

    always #5 clk = ~clk;

    always_comb begin
        s_msg = '0;
        for (int i = 0; i < N; i++) s_msg[i*MW +: MW] = m[i];
    end

    typedef struct {
        int            cyc;
        logic [MW-1:0] msg;
        int            src;
    } exp_t;

    exp_t exp_q [$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_on = 0;

    // Reference model state
    int   mptr;
    int   msent [N];
    int   mdropped;
    int   exp_stat;
    bit   stats_known = 0;
    int   bcast_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every broadcast must match the scoreboard entry due this cycle.
    always @(negedge clk) begin
        if (mon_on) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                chk("bcast_valid", 64'(bcast_valid), 64'd1);
                if (bcast_valid) begin
                    chk("bcast_msg", 64'(bcast_msg), 64'(exp_q[0].msg));
                    chk("bcast_src", 64'(bcast_src), 64'(exp_q[0].src));
                    bcast_seen++;
                end
                void'(exp_q.pop_front());
            end else begin
                chk("bcast_idle", 64'(bcast_valid), 64'd0);
            end
        end
    end

    // One clock of stimulus plus reference-model step.
    task automatic step(input logic [N-1:0] v, input logic [N-1:0] cr, input logic en,
                        input logic r, input logic [IW-1:0] sel, input logic clr, input bit keep);
        int g;
        int drops;
        logic [N-1:0] exp_ready;
        @(posedge clk);
        #1;
        if (stats_known) begin
            chk("stat_sent", 64'(stat_sent), 64'(exp_stat));
            chk("stat_dropped", 64'(stat_dropped), 64'(mdropped));
        end
        if (!keep) for (int i = 0; i < N; i++) m[i] = {$urandom(), $urandom()};
        s_valid = v; core_reset = cr; arb_enable = en; rst = r;
        stat_sel = sel; stat_clear = clr;
        #1;
        if (r) begin
            chk("s_ready_rst", 64'(s_ready), 64'd0);
            mptr = 0; mdropped = 0; exp_stat = 0;
            for (int i = 0; i < N; i++) msent[i] = 0;
            stats_known = 1;
        end else begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                int idx = (mptr + k) % N;
                if (g < 0 && en && v[idx] && !cr[idx]) g = idx;
            end
            exp_ready = cr;
            if (g >= 0) exp_ready[g] = 1'b1;
            chk("s_ready", 64'(s_ready), 64'(exp_ready));
            exp_stat = msent[sel];
            drops = 0;
            for (int i = 0; i < N; i++) if (v[i] && cr[i]) drops++;
            mdropped = (mdropped + drops > 65535) ? 65535 : mdropped + drops;
            if (g >= 0) begin
                exp_t e;
                e.cyc = cyc + 1; e.msg = m[g]; e.src = g;
                exp_q.push_back(e);
                if (msent[g] < 65535) msent[g]++;
                mptr = (g + 1) % N;
            end
            if (clr) msent[sel] = 0;
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) m[i] = '0;
        mptr = 0; mdropped = 0; exp_stat = 0;
        for (int i = 0; i < N; i++) msent[i] = 0;

        step('0, '0, 1'b0, 1'b1, 3'd0, 1'b0, 0);
        step('0, '0, 1'b0, 1'b1, 3'd0, 1'b0, 0);
        mon_on = 1;
        #2;
        chk("rst_bcast_valid", 64'(bcast_valid), 64'd0);
        chk("rst_bcast_msg", 64'(bcast_msg), 64'd0);
        chk("rst_bcast_src", 64'(bcast_src), 64'd0);

        // Single core 3 message, then read its sent counter.
        m[3] = 47'h0AB_CDEF01;
        step(8'b0000_1000, '0, 1'b1, 1'b0, 3'd3, 1'b0, 1);
        step('0, '0, 1'b1, 1'b0, 3'd3, 1'b0, 0);
        #2;
        chk("core3_src", 64'(bcast_src), 64'd3);
        chk("core3_msg", 64'(bcast_msg), 64'h0AB_CDEF01);
        step('0, '0, 1'b1, 1'b0, 3'd3, 1'b0, 0);
        #2;
        chk("core3_stat_sent", 64'(stat_sent), 64'd1);

        // All cores valid for 16 cycles after reset.
        step('0, '0, 1'b1, 1'b1, 3'd0, 1'b0, 0);
        for (int c = 0; c < 16; c++) step('1, '0, 1'b1, 1'b0, IW'(c % N), 1'b0, 0);
        for (int i = 0; i < N; i++) step('0, '0, 1'b1, 1'b0, IW'(i), 1'b0, 0);

        // Core 5 in reset alongside core 2.
        for (int c = 0; c < 3; c++) step(8'b0010_0100, 8'b0010_0000, 1'b1, 1'b0, 3'd2, 1'b0, 0);

        // Arbitration disabled, then re-enabled from ptr 0.
        step('0, '0, 1'b1, 1'b1, 3'd0, 1'b0, 0);
        for (int c = 0; c < 4; c++) step(8'b0100_0010, '0, 1'b0, 1'b0, 3'd1, 1'b0, 0);
        step(8'b0100_0010, '0, 1'b1, 1'b0, 3'd1, 1'b0, 0);
        step(8'b0100_0000, '0, 1'b1, 1'b0, 3'd6, 1'b0, 0);

        // Reset the cycle after a grant to core 4.
        step(8'b0001_0000, '0, 1'b1, 1'b0, 3'd4, 1'b0, 0);
        step('0, '0, 1'b1, 1'b1, 3'd4, 1'b0, 0);
        step(8'b1001_0000, '0, 1'b1, 1'b0, 3'd4, 1'b0, 0);
        step('0, '0, 1'b1, 1'b0, 3'd4, 1'b0, 0);

        // Randomized traffic with occasional resets, disables and clears.
        for (int c = 0; c < 2000; c++) begin
            logic [N-1:0] v, cr;
            v  = N'($urandom());
            cr = N'($urandom() & $urandom() & $urandom());
            step(v, cr, ($urandom_range(0, 9) != 0), ($urandom_range(0, 199) == 0),
                 IW'($urandom()), ($urandom_range(0, 15) == 0), 0);
        end

        // Saturate sent[0], then clear against a coincident grant.
        step('0, '0, 1'b1, 1'b1, 3'd0, 1'b0, 0);
        for (int c = 0; c < 65536; c++) step(8'b0000_0001, '0, 1'b1, 1'b0, 3'd0, 1'b0, 0);
        step('0, '0, 1'b1, 1'b0, 3'd0, 1'b0, 0);
        step('0, '0, 1'b1, 1'b0, 3'd0, 1'b0, 0);
        #2;
        chk("sat_sent0", 64'(stat_sent), 64'hFFFF);
        step(8'b0000_0001, '0, 1'b1, 1'b0, 3'd0, 1'b1, 0);
        step('0, '0, 1'b1, 1'b0, 3'd0, 1'b0, 0);
        step('0, '0, 1'b1, 1'b0, 3'd0, 1'b0, 0);
        #2;
        chk("clear_sent0", 64'(stat_sent), 64'd0);

        step('0, '0, 1'b1, 1'b0, 3'd0, 1'b0, 0);
        step('0, '0, 1'b1, 1'b0, 3'd0, 1'b0, 0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        checks++;
        if (bcast_seen < 100) begin
            failures++;
            $display("FAIL bcast_count: got %0d expected at least 100", bcast_seen);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
